spi_byte_bridge: RTL

- Clock-domain bridge between the mode-0 SPI slave byte shifter (clocked by SCK/CS) and the system clock domain of the CAN decoder.
- Buffers bytes received over SPI into an RX FIFO.
- Supplies outgoing bytes, such as decoded CAN frame bytes, from a TX FIFO to the shifter's parallel load input.
- One SPI transaction (CS low to CS high) carries exactly one WIDTH-bit byte in each direction.

---
 rtl/spi_byte_bridge_pkg.sv | 14 +
 rtl/spi_byte_bridge_fifo.sv | 66 ++++++
 rtl/spi_byte_bridge.sv | 123 ++++++++++++
 3 files changed

// File: rtl/spi_byte_bridge_pkg.sv
// Shared definitions for the SPI byte bridge and its FIFOs.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package spi_byte_bridge_pkg;

    // Byte driven to the shifter when no TX byte is held.
    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

    // Occupancy counters need one extra bit so that "full" (== depth) fits.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_byte_bridge_fifo.sv
// Synchronous first-word-fall-through FIFO with level count.
// Latency: a push into an empty FIFO is visible on out_vld/out_dat next cycle.
// Backpressure: in_rdy = not full; a push while full is taken only if a pop
//               happens in the same cycle (the pop frees the slot first).
// Ports: clk, rst_n | in_vld/in_rdy/in_dat write side |
//        out_vld/out_rdy/out_dat read side (head is registered storage) | level.
module sync_fifo
    import spi_byte_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int LW    = lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [LW-1:0]    level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             rd_ok;
    logic             wr_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign in_rdy  = ~full;
    assign out_vld = ~empty;
    assign out_dat = mem[rd_ptr];

    assign rd_ok = out_rdy & ~empty;
    assign wr_ok = in_vld & (~full | rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= in_dat;
    end

endmodule

// File: rtl/spi_byte_bridge.sv
// Bridges the SCK/CS-domain SPI byte shifter to the system clock: RX/TX FIFOs + TX hold.
// Latency: RX byte lands in the FIFO SYNC_STAGES+1 clk after CS rises; TX reload 1 clk after cs_rise.
// Backpressure: tx_ready = TX FIFO not full; RX bytes arriving on a full FIFO are dropped (rx_overflow).
// Ports: clk, rst_n | spi_cs, spi_p_out, spi_p_in shifter side |
//        tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_ready, tx_level, rx_level |
//        xfer_done pulse, rx_overflow/tx_underrun sticky flags, flag_clr.
module spi_byte_bridge
    import spi_byte_bridge_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 8,
    parameter logic [WIDTH-1:0] IDLE_BYTE   = WIDTH'(DEFAULT_IDLE_BYTE),
    parameter int               SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    spi_cs,
    input  logic [WIDTH-1:0]        spi_p_out,
    output logic [WIDTH-1:0]        spi_p_in,
    input  logic [WIDTH-1:0]        tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [WIDTH-1:0]        rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [lvl_w(DEPTH)-1:0] tx_level,
    output logic [lvl_w(DEPTH)-1:0] rx_level,
    output logic                    xfer_done,
    output logic                    rx_overflow,
    output logic                    tx_underrun,
    input  logic                    flag_clr
);

    // CS synchroniser; resets to all-ones so CS reads idle.
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   cs_s;
    logic                   cs_d;
    logic                   cs_rise;
    logic                   cs_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync <= '1;
            cs_d    <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            cs_d    <= cs_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign xfer_done = cs_rise;

    // TX path
    logic             tx_head_vld;
    logic [WIDTH-1:0] tx_head;
    logic             hold_valid;
    logic             load;

    // cs_d excludes the cs_rise cycle, so the earliest reload follows it.
    assign load = cs_s & cs_d & ~hold_valid & tx_head_vld;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (tx_valid & tx_ready),
        .in_rdy  (tx_ready),
        .in_dat  (tx_data),
        .out_vld (tx_head_vld),
        .out_rdy (load),
        .out_dat (tx_head),
        .level   (tx_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            spi_p_in   <= IDLE_BYTE;
        end else if (cs_rise) begin
            // Held byte counts as consumed even if the master aborted early.
            hold_valid <= 1'b0;
            spi_p_in   <= IDLE_BYTE;
        end else if (load) begin
            hold_valid <= 1'b1;
            spi_p_in   <= tx_head;
        end
    end

    // RX path: spi_p_out has been stable for SYNC_STAGES cycles by cs_rise.
    logic rx_in_rdy;
    logic rx_pop;

    assign rx_pop = rx_valid & rx_ready;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (cs_rise),
        .in_rdy  (rx_in_rdy),
        .in_dat  (spi_p_out),
        .out_vld (rx_valid),
        .out_rdy (rx_ready),
        .out_dat (rx_data),
        .level   (rx_level)
    );

    // Sticky flags: a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (cs_rise & ~rx_in_rdy & ~rx_pop) rx_overflow <= 1'b1;
            else if (flag_clr)                  rx_overflow <= 1'b0;

            if (cs_fall & ~hold_valid) tx_underrun <= 1'b1;
            else if (flag_clr)         tx_underrun <= 1'b0;
        end
    end

endmodule
